// File: rtl/if_pkg.sv
// +----------------------------------------------------------------------+
// | if_pkg : shared constants for the instruction-fetch stage            |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package if_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// +----------------------------------------------------------------------+
// | if_fetch_unit : PC owner, single-outstanding imem fetch, IF/ID feed  |
// | Optional perf counters enabled by IF_FETCH_PERF_CNT_EN               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_next,
  output logic [31:0] perf_delivered,
  output logic [31:0] perf_killed
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_fetch_pc_inc;
  logic        w_deliver_rsp;
  logic        w_deliver_hold;
  logic        w_discard;

  assign w_redirect_pc  = word_align(redirect_pc);
  assign w_fetch_pc_inc = r_fetch_pc + PC_INC;

  // A redirect flushes IF/ID this cycle, so it suppresses any delivery.
  assign w_deliver_rsp  = (r_state == S_WAIT) && imem_rsp_valid && !stall && !redirect_valid;
  assign w_deliver_hold = (r_state == S_HOLD) && !stall && !redirect_valid;
  assign w_discard      = !reset && imem_rsp_valid &&
                          (((r_state == S_WAIT) && redirect_valid) || (r_state == S_KILL));

  assign imem_req_valid = !reset && (r_state == S_REQ) && !redirect_valid;
  assign imem_addr      = r_pc;
  assign fetch_valid    = !reset && (w_deliver_rsp || w_deliver_hold);

  always_comb begin
    instruction = NOP_INSTR;
    pc_next     = 32'h0000_0000;
    if (fetch_valid) begin
      if (r_state == S_HOLD) begin
        instruction = r_hold_instr;
        pc_next     = r_hold_pc;
      end else begin
        instruction = imem_rsp_data;
        pc_next     = w_fetch_pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= word_align(RESET_PC);
      r_fetch_pc   <= 32'h0000_0000;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else if (imem_req_ready) begin
            r_fetch_pc <= r_pc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= imem_rsp_valid ? S_REQ : S_KILL;
          end else if (imem_rsp_valid) begin
            if (stall) begin
              r_hold_instr <= imem_rsp_data;
              r_hold_pc    <= w_fetch_pc_inc;
              r_state      <= S_HOLD;
            end else begin
              r_pc    <= w_fetch_pc_inc;
              r_state <= S_REQ;
            end
          end
        end
        S_KILL: begin
          // The stale response must drain before a new request can go out.
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_pc         <= w_redirect_pc;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= 32'h0000_0000;
            r_state      <= S_REQ;
          end else if (!stall) begin
            r_pc    <= r_hold_pc;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] r_perf_delivered;
  logic [31:0] r_perf_killed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_delivered <= 32'h0000_0000;
      r_perf_killed    <= 32'h0000_0000;
    end else begin
      if (fetch_valid) r_perf_delivered <= r_perf_delivered + 32'd1;
      if (w_discard)   r_perf_killed    <= r_perf_killed + 32'd1;
    end
  end

  assign perf_delivered = r_perf_delivered;
  assign perf_killed    = r_perf_killed;
`else
  logic w_unused_discard;
  assign w_unused_discard = w_discard;
  assign perf_delivered   = 32'h0000_0000;
  assign perf_killed      = 32'h0000_0000;
`endif

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC and issues one word fetch at a time to the instruction memory over a valid/ready request channel and a valid response channel. It delivers each instruction and its PC+4 to IF/ID, and emits an all-zero bubble (NOP) when it has nothing to deliver. It also applies stall and branch/jump redirects coming back from the ID stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset; bits [1:0] must be 0.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit hold; IF/ID will not accept this cycle
redirect_valid  input  1  taken branch or jump resolved in ID; same-cycle IF/ID flush
redirect_pc  input  32  target address; bits [1:0] are ignored and forced to 0
imem_req_valid  output  1  fetch request
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  32  fetched word
fetch_valid  output  1  instruction/pc_next outputs are real this cycle
instruction  output  32  fetched word, or 32'h0 when not valid
pc_next  output  32  fetch_pc+4, or 32'h0 when not valid
perf_delivered  output  32  delivered-instruction count (optional feature)
perf_killed  output  32  discarded-response count (optional feature)

Behaviour:
- Registers: pc (next fetch address), fetch_pc (address in flight), hold_instr/hold_pc, state.
- States: S_REQ, S_WAIT, S_KILL, S_HOLD.
- At most one request outstanding. Responses return in order, at least 1 cycle after the accepting handshake.
- Reset (synchronous): pc=RESET_PC, state=S_REQ, hold buffer=0. During reset: imem_req_valid=0, fetch_valid=0, instruction=0, pc_next=0.
- Outputs are combinational from state, response and hold buffer. IF/ID samples them on the same edge.
- S_REQ:
  - imem_req_valid = ~redirect_valid; imem_addr = pc.
  - Handshake: fetch_pc<=pc, go to S_WAIT.
  - redirect_valid: pc<=redirect_pc, stay in S_REQ, no request issued.
  - stall does not block issuing.
- S_WAIT, priority redirect > response:
  - redirect_valid and rsp_valid: discard response, pc<=redirect_pc, go to S_REQ.
  - redirect_valid alone: pc<=redirect_pc, go to S_KILL.
  - rsp_valid and stall: hold_instr<=data, hold_pc<=fetch_pc+4, go to S_HOLD; fetch_valid=0.
  - rsp_valid and ~stall: fetch_valid=1, instruction=data, pc_next=fetch_pc+4, pc<=fetch_pc+4, go to S_REQ.
- S_KILL:
  - rsp_valid: discard, go to S_REQ.
  - Further redirect_valid: update pc; if it coincides with rsp_valid, go to S_REQ.
  - fetch_valid=0.
- S_HOLD:
  - redirect_valid: drop buffer, pc<=redirect_pc, go to S_REQ.
  - ~stall: fetch_valid=1 with the hold values, pc<=hold_pc, go to S_REQ.
  - Otherwise stay in S_HOLD, fetch_valid=0.
- Whenever redirect_valid=1, fetch_valid=0; IF/ID flushes that cycle regardless.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Throughput: one instruction every 2 cycles with 1-cycle memory latency (non-pipelined by design).
- Reset mid-transaction drops any in-flight response. The memory side must also be reset by the same reset.

Optional Feature:
- Macro IF_FETCH_PERF_CNT_EN.
- Defined: perf_delivered increments on every cycle with fetch_valid=1. perf_killed increments on each discarded response (S_KILL response, or a redirect coinciding with rsp_valid in S_WAIT). Both are 32-bit, wrap, and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Decomposition:
- Shared package if_pkg: state encoding (S_REQ, S_WAIT, S_KILL, S_HOLD); NOP_INSTR=32'h0000_0000; PC_INC=32'd4.
- No sub-module: the hold buffer and the FSM are small and tightly coupled, so they stay inline.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, memory 1-cycle latency, words 0x1111_1111 then 0x2222_2222 -> first request addr 0x0040_0000; fetch_valid pulses with pc_next 0x0040_0004 then 0x0040_0008; instruction=0 between pulses.
- Stall held 3 cycles while response 0xAAAA_0001 arrives -> fetch_valid=0 during stall; on the cycle stall drops, fetch_valid=1 with 0xAAAA_0001; next request addr=fetch_pc+4; no request issued twice.
- Memory latency 4 cycles, redirect_pc=0x0000_0103 in first WAIT cycle -> state S_KILL; response dropped (perf_killed=1 with macro); next imem_addr=0x0000_0100.
- Redirect coincident with rsp_valid in S_WAIT -> fetch_valid=0; next imem_addr=redirect target; perf_delivered unchanged.
- imem_req_ready held low 5 cycles, with redirect at cycle 2 -> imem_req_valid=0 on the redirect cycle; imem_addr switches to target; handshake completes with the target address.
- pc=32'hFFFF_FFFC fetch -> pc_next=0x0000_0000 and next imem_addr=0x0000_0000; reset asserted in S_HOLD -> outputs 0 and first request at RESET_PC.
